// File: rtl/axis_dwidth_64to16_pkg.sv
// Shared AXI-Stream constants and helpers for the 64->16 width converter.
package axis_dwidth_64to16_pkg;

    localparam int AXIS_LANES     = 4;
    localparam int AXIS_LANE_W    = 16;
    localparam int AXIS_KEEP_W    = 2;
    localparam int AXIS_IN_W      = AXIS_LANES * AXIS_LANE_W;
    localparam int AXIS_IN_KEEP_W = AXIS_LANES * AXIS_KEEP_W;

    typedef logic [AXIS_LANES-1:0] lane_mask_t;
    typedef logic [1:0]            lane_idx_t;

    // Lane k is kept when its keep pair has any byte set, or always when
    // null lanes are to be emitted.
    function automatic lane_mask_t keep_to_mask(input logic [AXIS_IN_KEEP_W-1:0] tkeep,
                                                input logic skip_null);
        lane_mask_t m;
        for (int k = 0; k < AXIS_LANES; k++)
            m[k] = skip_null ? |tkeep[k*AXIS_KEEP_W +: AXIS_KEEP_W] : 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/axis_dwidth_64to16_lane_prio_enc.sv
// Lowest-set-bit encoder for the remaining-lane mask.
module lane_prio_enc
    import axis_dwidth_64to16_pkg::*;
(
    input  logic [AXIS_LANES-1:0] mask,
    output logic [1:0]            idx,
    output logic                  one_left
);

    // Scan from the top down so the lowest set bit wins; idx is 0 on an empty mask.
    always_comb begin
        idx = '0;
        for (int k = AXIS_LANES - 1; k >= 0; k--)
            if (mask[k]) idx = lane_idx_t'(k);
    end

    assign one_left = (mask != '0) && ((mask & (mask - lane_mask_t'(1))) == '0);

endmodule

// File: rtl/axis_dwidth_64to16.sv
// AXI-Stream 64-bit to 16-bit width converter with one-beat buffer,
// optional null-lane skipping and a master-side frame counter.
module axis_dwidth_64to16
    import axis_dwidth_64to16_pkg::*;
#(
    parameter int SKIP_NULL = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXIS_IN_W-1:0]      s_axis_tdata,
    input  logic [AXIS_IN_KEEP_W-1:0] s_axis_tkeep,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [AXIS_LANE_W-1:0]    m_axis_tdata,
    output logic [AXIS_KEEP_W-1:0]    m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [15:0]               frame_cnt,
    output logic                      null_last_drop
);

    logic [AXIS_LANES-1:0][AXIS_LANE_W-1:0] buf_data;
    logic [AXIS_LANES-1:0][AXIS_KEEP_W-1:0] buf_keep;
    lane_mask_t                             buf_mask;
    logic                                   buf_last;
    logic                                   buf_vld;

    lane_idx_t  cur_idx;
    logic       one_left;
    lane_mask_t new_mask;
    logic       m_hs;
    logic       s_hs;

    lane_prio_enc u_prio (
        .mask     (buf_mask),
        .idx      (cur_idx),
        .one_left (one_left)
    );

    assign new_mask = keep_to_mask(s_axis_tkeep, SKIP_NULL != 0);

    // Outputs are gated by rst_n so nothing leaks out before the first reset edge.
    assign m_axis_tvalid = rst_n && buf_vld && (buf_mask != '0);
    assign m_axis_tdata  = buf_data[cur_idx];
    assign m_axis_tkeep  = buf_keep[cur_idx];
    assign m_axis_tlast  = buf_last && one_left;

    // Accept a new beat while the final lane of the current one drains: no bubble.
    assign s_axis_tready = rst_n && (!buf_vld || (m_axis_tready && m_axis_tvalid && one_left));

    assign m_hs = m_axis_tvalid && m_axis_tready;
    assign s_hs = s_axis_tvalid && s_axis_tready;

    // Buffer load/drain, frame counting and the null-last pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_data       <= '0;
            buf_keep       <= '0;
            buf_mask       <= '0;
            buf_last       <= 1'b0;
            buf_vld        <= 1'b0;
            frame_cnt      <= '0;
            null_last_drop <= 1'b0;
        end else begin
            null_last_drop <= 1'b0;
            if (m_hs) begin
                buf_mask <= buf_mask & ~(lane_mask_t'(1) << cur_idx);
                if (one_left)     buf_vld   <= 1'b0;
                if (m_axis_tlast) frame_cnt <= frame_cnt + 16'd1;
            end
            // A beat with no kept lane never enters the buffer.
            if (s_hs) begin
                if (new_mask != '0) begin
                    buf_data <= s_axis_tdata;
                    buf_keep <= s_axis_tkeep;
                    buf_mask <= new_mask;
                    buf_last <= s_axis_tlast;
                    buf_vld  <= 1'b1;
                end else begin
                    null_last_drop <= s_axis_tlast;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_dwidth_64to16.sv
// Directed scoreboard bench for axis_dwidth_64to16 (SKIP_NULL=1).
module tb_axis_dwidth_64to16;

    localparam bit SKIP = 1'b1;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  k;
        logic        l;
    } word_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] m_tdata;
    logic [1:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [15:0] frame_cnt;
    logic        null_last_drop;

    axis_dwidth_64to16 #(.SKIP_NULL(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis_tdata   (s_tdata),
        .s_axis_tkeep   (s_tkeep),
        .s_axis_tlast   (s_tlast),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tkeep   (m_tkeep),
        .m_axis_tlast   (m_tlast),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .frame_cnt      (frame_cnt),
        .null_last_drop (null_last_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    acc_cyc = 0;
    int    pops = 0;
    int    null_pulses = 0;
    int    exp_frames = 0;
    word_t sb[$];
    int    pop_cyc[$];
    logic  pop_str[$];
    logic  prev_stall = 1'b0;
    word_t prev_w;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: compare each master handshake against the scoreboard and
    // verify outputs hold steady across stalls.
    always @(negedge clk) begin
        word_t got;
        word_t w;
        got = '{d: m_tdata, k: m_tkeep, l: m_tlast};
        if (rst_n && prev_stall) chk("stall_stable", got, prev_w);
        prev_stall = m_tvalid && !m_tready;
        prev_w     = got;
        if (null_last_drop) null_pulses++;
        if (m_tvalid && m_tready) begin
            chk("word_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                w = sb.pop_front();
                chk("word", got, w);
            end
            pops++;
            pop_cyc.push_back(cyc);
            pop_str.push_back(s_tready);
        end
    end

    // Drive one beat and push its expected output words; returns at posedge+1.
    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n;
        int lk;
        lk = -1;
        for (int i = 0; i < 4; i++)
            if (k[2*i +: 2] != 2'b00 || !SKIP) lk = i;
        for (int i = 0; i < 4; i++)
            if (k[2*i +: 2] != 2'b00 || !SKIP)
                sb.push_back('{d: d[16*i +: 16], k: k[2*i +: 2], l: l && (i == lk)});
        if (l && lk >= 0) exp_frames++;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_tready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("s_tready_timeout", s_tready, 1);
        acc_cyc = cyc;
        @(posedge clk);
        #1 s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || m_tvalid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        int np0;
        logic [15:0] fc0;
        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_null_drop", null_last_drop, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_s_tready", s_tready, 1);
        @(posedge clk);
        #1;

        // Full beat, lanes in order, last on lane 3, one-cycle latency
        pop_cyc.delete();
        send(64'h4444_3333_2222_1111, 8'hFF, 1'b1);
        drain();
        chk("full_count", pop_cyc.size(), 4);
        chk("latency", pop_cyc[0], acc_cyc + 1);
        chk("full_consecutive", pop_cyc[3] - pop_cyc[0], 3);
        chk("frame_cnt_1", frame_cnt, exp_frames);

        // Sparse keep: lanes 0 and 2 only
        p0 = pops;
        send(64'hDDDD_CCCC_BBBB_AAAA, 8'h33, 1'b1);
        drain();
        chk("sparse_count", pops - p0, 2);
        chk("frame_cnt_2", frame_cnt, exp_frames);

        // Partial keep pairs pass through unchanged
        p0 = pops;
        send(64'h0D0D_0C0C_0B0B_0A0A, 8'h09, 1'b1);
        drain();
        chk("partial_count", pops - p0, 2);

        // Two back-to-back full beats: 8 words, no bubble
        pop_cyc.delete();
        pop_str.delete();
        send(64'h8888_7777_6666_5555, 8'hFF, 1'b0);
        send(64'hCCCC_BBBB_AAAA_9999, 8'hFF, 1'b1);
        drain();
        chk("b2b_count", pop_cyc.size(), 8);
        chk("b2b_consecutive", pop_cyc[7] - pop_cyc[0], 7);
        chk("b2b_tready_at_4th", pop_str[3], 1);
        chk("frame_cnt_b2b", frame_cnt, exp_frames);

        // Ready toggling: stalls must hold outputs, order preserved
        fork
            send(64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b1);
            begin
                repeat (16) begin
                    @(posedge clk);
                    #1 m_tready = ~m_tready;
                end
            end
        join
        m_tready = 1'b1;
        drain();
        chk("frame_cnt_toggle", frame_cnt, exp_frames);

        // All-null last beat: dropped, pulse once, counter unchanged
        p0  = pops;
        np0 = null_pulses;
        fc0 = frame_cnt;
        send(64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("null_no_words", pops - p0, 0);
        chk("null_pulses", null_pulses - np0, 1);
        chk("null_frame_cnt", frame_cnt, fc0);

        // Reset after two of four lanes
        p0 = pops;
        send(64'h4040_3030_2020_1010, 8'hFF, 1'b1);
        begin
            int n;
            n = 0;
            while (pops < p0 + 2 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("midrst_two_sent", pops - p0, 2);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_s_tready", s_tready, 0);
        @(posedge clk);
        #1;
        sb.delete();
        exp_frames = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        p0 = pops;
        @(negedge clk);
        chk("midrst_rel_s_tready", s_tready, 1);
        chk("midrst_rel_m_tvalid", m_tvalid, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        @(posedge clk);
        #1;
        chk("midrst_no_residual", pops - p0, 0);
        send(64'h0004_0003_0002_0001, 8'hFF, 1'b1);
        drain();
        chk("midrst_after_count", pops - p0, 4);
        chk("midrst_after_frames", frame_cnt, exp_frames);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_dwidth_64to16.md
AXIS_DWIDTH_64TO16 -- requirements
Module: axis_dwidth_64to16

Interface
REQ-001 SHALL have parameter: SKIP_NULL, 1, 1 = drop 16-bit lanes whose TKEEP pair is 2'b00; 0 = emit them.
REQ-002 SHALL have ports:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- s_axis_tdata, in, 64, input beat; lane k = bits [16k+15:16k].
- s_axis_tkeep, in, 8, byte enables.
- s_axis_tlast, in, 1, last beat of frame.
- s_axis_tvalid, in, 1, input beat valid.
- s_axis_tready, out, 1, input beat accepted when high with tvalid.
- m_axis_tdata, out, 16, output word to the TX serializer.
- m_axis_tkeep, out, 2, byte enables of output word.
- m_axis_tlast, out, 1, last word of frame.
- m_axis_tvalid, out, 1, output word valid.
- m_axis_tready, in, 1, downstream ready.
- frame_cnt, out, 16, count of frames completed on master side.
- null_last_drop, out, 1, one-cycle pulse: a TLAST beat was dropped with no emitted lane.
REQ-003 Reset SHALL be rst_n, synchronous, active-low; clock SHALL be clk.

Function
REQ-004 SHALL hold one accepted beat in a buffer: data, remaining-lane mask, last flag, valid flag.
REQ-005 SHALL emit lanes lowest index first (lane 0 first); the current lane SHALL be the lowest set bit of the remaining mask.
REQ-006 On beat accept, the mask bit for lane k SHALL be set iff tkeep[2k+1:2k] != 0 (SKIP_NULL=1), or always set (SKIP_NULL=0).
REQ-007 m_axis_tdata/m_axis_tkeep SHALL be the current lane's data and keep pair; partial pairs (01/10) SHALL pass unchanged.
REQ-008 m_axis_tvalid SHALL be buffer valid AND mask nonzero.
REQ-009 m_axis_tlast SHALL be buffer last flag AND the current lane is the only remaining mask bit.
REQ-010 On a master handshake, the current lane's mask bit SHALL clear; the buffer SHALL empty when the mask reaches zero.
REQ-011 s_axis_tready SHALL be combinational: (NOT buffer valid) OR (m_axis_tready AND m_axis_tvalid AND one mask bit remaining), so back-to-back beats run with no bubble.
REQ-012 Latency: first lane SHALL be valid on m_axis the cycle after the slave handshake.
REQ-013 Master outputs SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-014 An accepted beat whose computed mask is zero SHALL be dropped without occupying the buffer.
- If that beat has tlast=1, null_last_drop SHALL pulse for one cycle.
- frame_cnt SHALL NOT change.
REQ-015 frame_cnt SHALL increment on each master handshake with m_axis_tlast=1, wrapping 0xFFFF -> 0x0000.
REQ-016 Throughput: 1 word/cycle sustained when m_axis_tready=1.

Reset
REQ-017 While rst_n=0: buffer valid=0, mask=0, m_axis_tvalid=0, s_axis_tready=0, frame_cnt=0, null_last_drop=0.
REQ-018 Reset mid-frame SHALL discard the buffered beat; no partial word SHALL be emitted after release.
REQ-019 s_axis_tready SHALL be 1 in the first cycle after release.

Structure
REQ-020 Lane count (4), lane width (16) and keep-pair width (2) SHALL be constants in the shared axis package.
REQ-021 The lowest-set-bit lane select SHALL be a sub-module, lane_prio_enc (4-bit mask in, 2-bit index and "one remaining" flag out).
REQ-022 No other sub-module; single clock domain.

Verification
REQ-023 Beat 0x4444_3333_2222_1111, tkeep=FF, tlast=1, m_tready=1 -> words 1111, 2222, 3333, 4444 on consecutive cycles; tlast only on 4444; frame_cnt=1.
REQ-024 tkeep=0x33 (lanes 0 and 2) -> exactly 2 words, lane0 then lane2; with tlast=1 on the beat, tlast on lane2.
REQ-025 Two back-to-back full beats with m_tready=1 -> 8 words in 8 consecutive cycles; s_tready high in the cycle the 4th word handshakes.
REQ-026 m_tready toggles 1/0 each cycle -> data, keep and last stable during stalls; order preserved.
REQ-027 Beat tkeep=00, tlast=1 -> no master word; null_last_drop pulses once; frame_cnt unchanged.
REQ-028 rst_n=0 after 2 of 4 lanes have been sent, then released -> no residual words; next beat emitted from lane 0; frame_cnt=0.
